// File: rtl/systolic_os_array.sv
// ---------------------------------------------------------------------------
// systolic_os_array
//
// Output-stationary N x N systolic matrix multiplier. For a job of K steps,
// beat k provides one weight row (w_vec) and one data column (d_vec). Each PE
// (i,j) accumulates C[i][j] = sum_k d_k[i] * w_k[j]. When the job finishes,
// the result matrix is read out one row at a time.
//
// The block skews its inputs internally, so callers present plain, unskewed
// vectors. After the K load beats, 2*N-1 flush cycles drain the wavefront.
// The rows are then presented through a valid/ready handshake.
//
// Optional feature: define SYSTOLIC_SAT_EN to make every accumulate saturate
// instead of wrapping modulo 2^ACC_WIDTH.
//
// Ports
//   clk          rising-edge clock
//   srstn        asynchronous active-low reset
//   start        begin a job (sampled only when idle)
//   k_len        accumulation length K, latched on an accepted start
//   in_valid     w_vec/d_vec carry a beat
//   in_ready     block accepts a beat (high only while loading)
//   w_vec        weight row, lane j -> column j, lane 0 in MSBs
//   d_vec        data column, lane i -> row i, lane 0 in MSBs
//   out_valid    out_row holds a result row
//   out_ready    consumer accepts the row
//   out_row      C[out_row_idx][0..N-1], lane 0 in MSBs
//   out_row_idx  index of the row presented
//   busy         high whenever not idle
//   done         one-cycle pulse after the final row is accepted
// ---------------------------------------------------------------------------
module systolic_os_array #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+5,
    parameter int KLEN_WIDTH = 16,
    localparam int IDX_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             start,
    input  logic [KLEN_WIDTH-1:0]            k_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_vec,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] d_vec,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
    output logic [IDX_W-1:0]                 out_row_idx,
    output logic                             busy,
    output logic                             done
);

    localparam int N       = ARRAY_SIZE;
    localparam int PROD_W  = 2*DATA_WIDTH;
    localparam int FLUSH_W = $clog2(2*ARRAY_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t                 state;
    logic [KLEN_WIDTH-1:0]  k_target;
    logic [KLEN_WIDTH-1:0]  k_cnt;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic [IDX_W-1:0]       row_idx;
    logic                   done_q;

    logic start_acc;
    logic advance;

    logic signed [DATA_WIDTH-1:0] d_lane [N];
    logic signed [DATA_WIDTH-1:0] w_lane [N];
    logic signed [DATA_WIDTH-1:0] d_edge [N];
    logic signed [DATA_WIDTH-1:0] w_edge [N];

    // Skew chains: lane i uses stages 0..i-1. Higher stages are dead and get
    // trimmed.
    logic signed [DATA_WIDTH-1:0] d_sk [N][N];
    logic signed [DATA_WIDTH-1:0] w_sk [N][N];

    logic signed [DATA_WIDTH-1:0] a_reg [N][N];
    logic signed [DATA_WIDTH-1:0] b_reg [N][N];
    logic signed [ACC_WIDTH-1:0]  acc      [N][N];
    logic signed [ACC_WIDTH-1:0]  acc_nxt  [N][N];
    logic signed [PROD_W-1:0]     prod     [N][N];
    logic signed [ACC_WIDTH-1:0]  prod_ext [N][N];
`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH:0] sum_wide [N][N];
`endif

    assign start_acc   = (state == IDLE) && start;
    // A stall cycle in LOAD leaves the whole array untouched.
    assign advance     = ((state == LOAD) && in_valid) || (state == FLUSH);

    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == DRAIN);
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign out_row_idx = row_idx;

    // Input lanes. Zeros are injected while flushing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            d_lane[i] = '0;
            w_lane[i] = '0;
            if (state == LOAD) begin
                d_lane[i] = d_vec[(N-i)*DATA_WIDTH-1 -: DATA_WIDTH];
                w_lane[i] = w_vec[(N-i)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end
    end

    // Array edge operands after the per-lane skew delay.
    always_comb begin
        d_edge[0] = d_lane[0];
        w_edge[0] = w_lane[0];
        for (int i = 1; i < N; i++) begin
            d_edge[i] = d_sk[i][i-1];
            w_edge[i] = w_sk[i][i-1];
        end
    end

    // MAC for every PE, computed from the operands held before the advance.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j]     = PROD_W'(a_reg[i][j]) * PROD_W'(b_reg[i][j]);
                prod_ext[i][j] = ACC_WIDTH'(prod[i][j]);
`ifdef SYSTOLIC_SAT_EN
                sum_wide[i][j] = {acc[i][j][ACC_WIDTH-1], acc[i][j]}
                               + {prod_ext[i][j][ACC_WIDTH-1], prod_ext[i][j]};
                // Top two bits disagree means the true sum left the range.
                if (sum_wide[i][j][ACC_WIDTH] != sum_wide[i][j][ACC_WIDTH-1])
                    acc_nxt[i][j] = sum_wide[i][j][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                else
                    acc_nxt[i][j] = sum_wide[i][j][ACC_WIDTH-1:0];
`else
                acc_nxt[i][j] = acc[i][j] + prod_ext[i][j];
`endif
            end
        end
    end

    // Skew chains, operand pipelines and accumulators.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    d_sk[i][j]  <= '0;
                    w_sk[i][j]  <= '0;
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (start_acc) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    d_sk[i][j]  <= '0;
                    w_sk[i][j]  <= '0;
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                d_sk[i][0] <= d_lane[i];
                w_sk[i][0] <= w_lane[i];
                for (int m = 1; m < N; m++) begin
                    d_sk[i][m] <= d_sk[i][m-1];
                    w_sk[i][m] <= w_sk[i][m-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= (j == 0) ? d_edge[i] : a_reg[i][(j == 0) ? 0 : j-1];
                    b_reg[i][j] <= (i == 0) ? w_edge[j] : b_reg[(i == 0) ? 0 : i-1][j];
                    acc[i][j]   <= acc_nxt[i][j];
                end
            end
        end
    end

    // Job control.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state     <= IDLE;
            k_target  <= '0;
            k_cnt     <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_target  <= k_len;
                        k_cnt     <= '0;
                        flush_cnt <= '0;
                        row_idx   <= '0;
                        state     <= (k_len == '0) ? FLUSH : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (k_cnt == k_target - 1'b1) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_W'(2*N-2)) begin
                        row_idx <= '0;
                        state   <= DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_idx == IDX_W'(N-1)) begin
                            row_idx <= '0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result row mux. Outputs are zero outside DRAIN.
    always_comb begin
        out_row = '0;
        if (state == DRAIN) begin
            for (int j = 0; j < N; j++)
                out_row[(N-j)*ACC_WIDTH-1 -: ACC_WIDTH] = acc[row_idx][j];
        end
    end

endmodule

// File: tb/tb_systolic_os_array.sv
// ---------------------------------------------------------------------------
// tb_systolic_os_array
//
// Directed bench for systolic_os_array at N=4, 8-bit operands, 21-bit
// accumulators. It runs these jobs in order:
//   - reset state check
//   - uniform 2x3 job
//   - identity-weight job, back-to-back beats
//   - identity-weight job with stalls, mid-job start/k_len noise and an
//     output hold on row 1
//   - 64-step overflow job
//   - reset pulse mid-flush, followed by a fresh job
// ---------------------------------------------------------------------------
module tb_systolic_os_array;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2*DW+5;
    localparam int KW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              srstn;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   w_vec;
    logic [N*DW-1:0]   d_vec;
    logic              out_valid;
    logic              out_ready;
    logic [N*AW-1:0]   out_row;
    logic [IW-1:0]     out_row_idx;
    logic              busy;
    logic              done;

    int tests    = 0;
    int failures = 0;
    int expC [N][N];

    systolic_os_array #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .KLEN_WIDTH (KW)
    ) dut (
        .clk         (clk),
        .srstn       (srstn),
        .start       (start),
        .k_len       (k_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .w_vec       (w_vec),
        .d_vec       (d_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [N*DW-1:0] packVec(input int l0, input int l1,
                                                input int l2, input int l3);
        logic [N*DW-1:0] v;
        v = {DW'(l0), DW'(l1), DW'(l2), DW'(l3)};
        return v;
    endfunction

    function automatic logic signed [63:0] rowLane(input int j);
        logic signed [AW-1:0] v;
        v = out_row[(N-j)*AW-1 -: AW];
        return v;
    endfunction

    task automatic startJob(input int k);
        int guard = 0;
        while (busy && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) checkOutput("idle_timeout", 0, 1);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        k_len = 16'd9;
        checkOutput("busy_after_start", busy, 1);
    endtask

    // One beat; 'gap' stall cycles follow with junk operands and start high.
    task automatic applyStimulus(input logic [N*DW-1:0] w, input logic [N*DW-1:0] d,
                                 input int gap);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        w_vec    = w;
        d_vec    = d;
        tick();
        in_valid = 1'b0;
        w_vec    = '1;
        d_vec    = packVec(99, -77, 55, 33);
        for (int g = 0; g < gap; g++) begin
            start = 1'b1;
            k_len = 16'd2;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic collectRows(input int holdRow);
        int guard = 0;
        logic [N*AW-1:0] snap;
        while (!out_valid && guard < 300) begin
            checkOutput("in_ready_before_drain_low", in_ready & ~busy, 0);
            tick();
            guard++;
        end
        if (guard >= 300) checkOutput("out_valid_timeout", 0, 1);
        for (int r = 0; r < N; r++) begin
            checkOutput($sformatf("row%0d_valid", r), out_valid, 1);
            checkOutput($sformatf("row%0d_idx", r), out_row_idx, r);
            checkOutput($sformatf("row%0d_in_ready", r), in_ready, 0);
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("row%0d_lane%0d", r, j), rowLane(j), expC[r][j]);
            if (r == holdRow) begin
                out_ready = 1'b0;
                snap = out_row;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    checkOutput("hold_idx", out_row_idx, r);
                    checkOutput("hold_row_stable", out_row === snap, 1);
                    checkOutput("hold_done_low", done, 0);
                end
            end
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        checkOutput("done_pulse", done, 1);
        checkOutput("out_valid_after_drain", out_valid, 0);
        checkOutput("busy_after_drain", busy, 0);
        tick();
        checkOutput("done_single_cycle", done, 0);
    endtask

    task automatic runUniformJob();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                expC[i][j] = 6;
        startJob(1);
        applyStimulus(packVec(2, 2, 2, 2), packVec(3, 3, 3, 3), 0);
        checkOutput("in_ready_after_last_beat", in_ready, 0);
        collectRows(-1);
    endtask

    task automatic runIdentityJob(input int gap, input int holdRow);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                expC[i][j] = i*4 + j;
        startJob(4);
        for (int k = 0; k < N; k++)
            applyStimulus(packVec(k == 0, k == 1, k == 2, k == 3),
                          packVec(k, 4 + k, 8 + k, 12 + k), gap);
        checkOutput("in_ready_after_identity", in_ready, 0);
        collectRows(holdRow);
    endtask

    initial begin
        srstn     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        w_vec     = '0;
        d_vec     = '0;
        out_ready = 1'b0;

        #2;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_out_row_zero", out_row == '0, 1);
        checkOutput("reset_row_idx", out_row_idx, 0);
        #10;
        srstn = 1'b1;
        tick();

        $display("[TB] uniform K=1 job");
        runUniformJob();

        $display("[TB] identity K=4 job");
        runIdentityJob(0, -1);

        $display("[TB] identity K=4 job with stalls and row 1 hold");
        runIdentityJob(1, 1);

        $display("[TB] K=64 overflow job");
`ifdef SYSTOLIC_SAT_EN
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                expC[i][j] = 1048575;
`else
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                expC[i][j] = -1048576;
`endif
        startJob(64);
        for (int k = 0; k < 64; k++)
            applyStimulus(packVec(-128, -128, -128, -128),
                          packVec(-128, -128, -128, -128), 0);
        collectRows(-1);

        $display("[TB] reset mid-flush");
        startJob(1);
        applyStimulus(packVec(5, 6, 7, 8), packVec(1, 2, 3, 4), 0);
        tick();
        tick();
        checkOutput("flush_busy", busy, 1);
        #3;
        srstn = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_in_ready", in_ready, 0);
        checkOutput("async_out_valid", out_valid, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_out_row_zero", out_row == '0, 1);
        checkOutput("async_row_idx", out_row_idx, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("reset_no_done", done, 0);
        end
        srstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checkOutput("post_reset_no_done", done, 0);
            checkOutput("post_reset_idle", busy, 0);
        end
        runUniformJob();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/systolic_os_array.md
SYSTOLIC_OS_ARRAY -- requirements
Module: systolic_os_array

Interface
REQ-001 Parameter ARRAY_SIZE, default 8: PE rows and columns, N x N.
REQ-002 Parameter DATA_WIDTH, default 8: signed operand width.
REQ-003 Parameter ACC_WIDTH, default 2*DATA_WIDTH+5: signed accumulator width.
REQ-004 Parameter KLEN_WIDTH, default 16: width of the accumulation-length field.
REQ-005 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 Port srstn, input, 1: reset, asynchronous assertion, active-low.
REQ-007 Port start, input, 1: begin a job; sampled only in IDLE.
REQ-008 Port k_len, input, KLEN_WIDTH: accumulation steps K; latched on an accepted start.
REQ-009 Port in_valid, input, 1: w_vec and d_vec carry one beat.
REQ-010 Port in_ready, output, 1: block accepts a beat.
REQ-011 Port w_vec, input, ARRAY_SIZE*DATA_WIDTH: weight row k, lane j feeds column j.
REQ-012 Port d_vec, input, ARRAY_SIZE*DATA_WIDTH: data column k, lane i feeds row i.
REQ-013 Port out_valid, output, 1: out_row holds a result row.
REQ-014 Port out_ready, input, 1: consumer accepts the result row.
REQ-015 Port out_row, output, ARRAY_SIZE*ACC_WIDTH: result row C[out_row_idx][0..N-1].
REQ-016 Port out_row_idx, output, $clog2(ARRAY_SIZE) (minimum 1): index of the row presented.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port done, output, 1: single-cycle pulse after the last row is accepted.
REQ-019 Lane packing: lane 0 occupies the MSBs; lane i sits at bits [(N-i)*W-1 -: W], W = DATA_WIDTH or ACC_WIDTH.

Function
REQ-020 Result: C[i][j] = sum over k=0..K-1 of d_k[i]*w_k[j], where beat k is the k-th accepted input beat.
REQ-021 FSM states are IDLE, LOAD, FLUSH and DRAIN.
REQ-022 IDLE->LOAD on start=1 when k_len>0; IDLE->FLUSH on start=1 when k_len=0.
REQ-023 Every accumulator and operand register clears to 0 on the cycle start is accepted.
REQ-024 in_ready = 1 only in LOAD; a beat transfers when in_valid and in_ready are both 1.
REQ-025 LOAD accepts exactly K beats, then moves to FLUSH.
REQ-026 The array advances only on a transferred beat or on a FLUSH cycle; a stall cycle changes no array state.
REQ-027 Skew: d lane i is delayed i advances and w lane j is delayed j advances inside the block; callers supply unskewed vectors.
REQ-028 On each advance, data shifts right, weights shift down, and every PE adds the product of its pre-advance operands.
REQ-029 FLUSH injects zero operands for exactly 2*ARRAY_SIZE-1 cycles, then moves to DRAIN.
REQ-030 DRAIN presents rows 0..N-1 in order with out_valid=1; the row index increments on out_valid&&out_ready.
REQ-031 out_row and out_row_idx hold stable while out_valid=1 and out_ready=0.
REQ-032 When the row N-1 handshake completes: done=1 on the next cycle, state returns to IDLE, and out_valid=0.
REQ-033 start while busy=1 is ignored; k_len changes after a job is accepted have no effect.
REQ-034 Product: signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH, added modulo 2^ACC_WIDTH.

Reset
REQ-035 With srstn=0, immediately (no clock needed): state=IDLE, all array, skew, counter and accumulator registers = 0, in_ready=0, out_valid=0, busy=0, done=0, out_row=0, out_row_idx=0.
REQ-036 Reset in any state aborts the job; no done pulse is issued; the first start after srstn=1 runs normally.

Configuration
REQ-037 With macro SYSTOLIC_SAT_EN defined, each accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; without it, accumulation wraps as in REQ-034.

Verification
REQ-038 N=4, K=1, every w lane 2, every d lane 3 -> four rows of 6,6,6,6, idx 0..3, then one done pulse.
REQ-039 N=4, K=4, w = identity rows, d_k = column k of A with A[i][k]=i*4+k -> C equals A, e.g. row 1 = 4,5,6,7.
REQ-040 REQ-039 stimulus with in_valid toggled every other cycle -> identical C; in_ready is never high outside LOAD.
REQ-041 DRAIN with out_ready=0 for 5 cycles on row 1 -> out_row_idx stays 1 and out_row does not change.
REQ-042 Defaults, K=64, all operands -128 -> 1048576 overflows the 21-bit accumulator: -1048576 without SYSTOLIC_SAT_EN, 1048575 with it.
REQ-043 srstn pulsed low mid-FLUSH -> all outputs are 0 asynchronously with no done pulse; a fresh K=1 job then gives the REQ-038 result.
